instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 89 ++++++++
 tb/tb_instr_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch feeding a 2-entry decode FIFO, with redirect flush
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);
  typedef enum logic [1:0] {FETCH, WAIT, DROP, FULL} state_t;
  state_t      state, state_n;
  logic        started, rd, wr, hs, push, pop, outst;
  logic [1:0]  count, count_n;
  logic [31:0] pc, raddr;
  logic [31:0] fpc [2];
  logic [31:0] fins [2];
  assign imem_req_valid = started && state == FETCH;
  assign imem_req_addr  = pc;
  assign hs      = imem_req_valid && imem_req_ready;
  assign outst   = state == WAIT || state == DROP;
  assign push    = state == WAIT && imem_rsp_valid && !redirect_valid;
  assign pop     = id_valid && id_ready && !redirect_valid;
  assign count_n = count + {1'b0, push} - {1'b0, pop};
  assign wr      = rd ^ (count == 2'd1);
  assign id_valid = count != 2'd0;
  assign id_pc    = fpc[rd];
  assign id_instr = fins[rd];
  assign opcode   = id_instr[6:0];
  assign funct3   = id_instr[14:12];
  assign funct7   = id_instr[31:25];
  // next state: a redirect wins; a response landing in the redirect cycle retires the stale request
  always_comb begin
    state_n = state;
    if (redirect_valid) state_n = (hs || (outst && !imem_rsp_valid)) ? DROP : FETCH;
    else case (state)
      FETCH:   state_n = hs ? WAIT : FETCH;
      WAIT:    state_n = !imem_rsp_valid ? WAIT : count_n < 2'd2 ? FETCH : FULL;
      DROP:    state_n = imem_rsp_valid ? FETCH : DROP;
      default: state_n = count_n < 2'd2 ? FETCH : FULL;
    endcase
  end
  // fsm, pc, address of the outstanding request, and the one-cycle post-reset request gate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      started <= 1'b0;
      pc      <= RESET_PC;
      raddr   <= RESET_PC;
    end else begin
      state   <= state_n;
      started <= 1'b1;
      if (redirect_valid) pc <= redirect_pc & ~32'd3;
      else if (hs) pc <= pc + 32'd4;
      if (hs) raddr <= pc;
    end
  end
  // decode FIFO: redirect flushes, otherwise push and pop may coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 2'd0;
      rd      <= 1'b0;
      fpc[0]  <= '0;
      fpc[1]  <= '0;
      fins[0] <= '0;
      fins[1] <= '0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      count <= count_n;
      if (pop) rd <= ~rd;
      if (push) begin
        fpc[wr]  <= raddr;
        fins[wr] <= imem_rsp_data;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random fetch traffic checked against a credit/queue reference model
module tb_instr_fetch;
  localparam logic [31:0] RP = 32'h0000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, id_valid, id_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, id_pc, id_instr;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  instr_fetch #(.RESET_PC(RP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .opcode(opcode), .funct3(funct3), .funct7(funct7)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  int total = 0;
  int bad = 0;
  ent_t mq[$];
  logic m_started, m_out, m_stale;
  logic [31:0] m_pc, m_raddr;
  logic mem_busy, lat_rand, popped, found;
  int mem_left, lat, k;
  logic [31:0] mem_addr, popped_pc;
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    m_started = 1'b0;
    m_out = 1'b0;
    m_stale = 1'b0;
    m_pc = RP;
    m_raddr = RP;
  endtask
  task automatic chk_zero();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_funct3", funct3, 0);
    chk("rst_funct7", funct7, 0);
  endtask
  task automatic tick();
    logic rsp, mreqv, mhs, mpop, dhs;
    logic [31:0] rdata, daddr;
    ent_t e;
    rsp = mem_busy && mem_left == 0;
    rdata = rsp ? instr_of(mem_addr) : $urandom;
    imem_rsp_valid = rsp;
    imem_rsp_data = rdata;
    #1;
    mreqv = m_started && !m_out && mq.size() < 2;
    chk("req_valid", imem_req_valid, mreqv);
    if (mreqv) chk("req_addr", imem_req_addr, m_pc);
    chk("id_valid", id_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("id_pc", id_pc, mq[0].pc);
      chk("id_instr", id_instr, mq[0].instr);
      chk("opcode", opcode, mq[0].instr[6:0]);
      chk("funct3", funct3, mq[0].instr[14:12]);
      chk("funct7", funct7, mq[0].instr[31:25]);
    end
    if (!rst_n) chk_zero();
    dhs = imem_req_valid && imem_req_ready;
    daddr = imem_req_addr;
    mhs = mreqv && imem_req_ready;
    mpop = mq.size() > 0 && id_ready;
    popped = rst_n && mpop && !redirect_valid;
    popped_pc = id_pc;
    @(posedge clk);
    if (rst_n) begin
      if (redirect_valid) begin
        mq.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        if (mhs) begin
          m_out = 1'b1;
          m_stale = 1'b1;
        end else if (m_out && rsp) m_out = 1'b0;
        else if (m_out) m_stale = 1'b1;
      end else begin
        if (mpop) void'(mq.pop_front());
        if (m_out && rsp) begin
          if (!m_stale) begin
            e.pc = m_raddr;
            e.instr = rdata;
            mq.push_back(e);
          end
          m_out = 1'b0;
          m_stale = 1'b0;
        end
        if (mhs) begin
          m_out = 1'b1;
          m_stale = 1'b0;
          m_raddr = m_pc;
          m_pc = m_pc + 32'd4;
        end
      end
      m_started = 1'b1;
    end
    if (rsp) mem_busy = 1'b0;
    else if (mem_busy) mem_left--;
    if (dhs) begin
      mem_busy = 1'b1;
      mem_addr = daddr;
      mem_left = lat_rand ? int'($urandom_range(2, 0)) : lat - 1;
    end
    @(negedge clk);
  endtask
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    mem_busy = 1'b0;
    #1;
    model_reset();
    chk_zero();
    repeat (n) tick();
    rst_n = 1'b1;
  endtask
  task automatic wait_req(input string tag);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req_valid) found = 1'b1;
      else tick();
    end
    chk(tag, found, 1);
  endtask
  task automatic wait_inflight(input string tag);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_out && !m_stale && mem_busy && mem_left > 0) found = 1'b1;
      else tick();
    end
    chk(tag, found, 1);
  endtask
  initial begin
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    lat = 1;
    lat_rand = 1'b0;
    mem_busy = 1'b0;
    mem_left = 0;
    mem_addr = '0;
    model_reset();
    @(negedge clk);
    do_reset(2);
    k = 0;
    repeat (24) begin
      tick();
      if (popped) begin
        chk("seq_pc", popped_pc, k * 4);
        k++;
      end
    end
    chk("seq_rate", k, 11);
    id_ready = 1'b0;
    repeat (10) tick();
    chk("full_req_valid", imem_req_valid, 0);
    chk("full_id_valid", id_valid, 1);
    id_ready = 1'b1;
    repeat (8) tick();
    lat = 3;
    wait_inflight("reach_wait");
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    wait_req("refetch");
    chk("redirect_addr", imem_req_addr, 32'h0000_0100);
    repeat (10) tick();
    lat = 1;
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    tick();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mq.size() == 1 && m_out && !m_stale && mem_busy && mem_left == 0) found = 1'b1;
      else tick();
    end
    chk("reach_one_entry", found, 1);
    redirect_valid = 1'b1;
    redirect_pc = $urandom;
    tick();
    redirect_valid = 1'b0;
    chk("flush_id_valid", id_valid, 0);
    chk("flush_req_valid", imem_req_valid, 1);
    id_ready = 1'b1;
    repeat (10) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_req("wrap_first");
    chk("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    wait_req("wrap_next");
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);
    repeat (6) tick();
    lat = 3;
    wait_inflight("reach_wait_rst");
    do_reset(1);
    mem_busy = 1'b1;
    mem_left = 0;
    mem_addr = 32'hDEAD_BEE0;
    tick();
    wait_req("restart");
    chk("restart_addr", imem_req_addr, RP);
    repeat (10) tick();
    lat_rand = 1'b1;
    repeat (2000) begin
      imem_req_ready = $urandom_range(9, 0) < 6;
      id_ready = $urandom_range(9, 0) < 7;
      redirect_valid = $urandom_range(19, 0) == 0;
      redirect_pc = $urandom;
      if ($urandom_range(299, 0) == 0) do_reset(1);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
